// File: rtl/monitor_pkg.sv
// Shared definitions for the CPU boot monitor: state encodings,
// command/reply byte values and the transfer-length helper.
package monitor_pkg;

  // Main command sequencer states
  typedef enum logic [3:0] {
    S_IDLE,
    S_GETAH,
    S_GETAL,
    S_GETLEN,
    S_LOAD,
    S_RDADDR,
    S_RDW1,
    S_RDW2,
    S_TXSEND,
    S_TXWAIT,
    S_RUN,
    S_RUNWAIT,
    S_ACK
  } mon_state_e;

  // Byte-send helper states
  typedef enum logic [1:0] {
    T_IDLE,
    T_SEND,
    T_HOLD,
    T_WAIT
  } tx_state_e;

  // Command opcodes
  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'

  // Reply bytes
  localparam logic [7:0] RPL_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] RPL_HALT = 8'h48;  // 'H'
  localparam logic [7:0] RPL_ERR  = 8'h3F;  // '?'

  // A length byte of zero stands for a full 256-byte transfer.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/cpu_monitor_if.sv
// Bundle of the UART, RAM and CPU-control signals seen by the boot monitor.
// "master" is the monitor side, "slave" is the surrounding system.
interface cpu_monitor_if #(
  parameter int ADDR_WIDTH = 9
);
  logic [7:0]            rx_byte;
  logic                  received;
  logic [7:0]            tx_byte;
  logic                  transmit;
  logic                  is_transmitting;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [7:0]            mem_dread;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [7:0]            mem_dwrite;
  logic                  mem_write_en;
  logic                  cpu_run;
  logic [ADDR_WIDTH-1:0] cpu_startaddr;
  logic                  cpu_halted;
  logic                  cpu_active;

  modport master (
    input  rx_byte, received, is_transmitting, mem_dread, cpu_halted,
    output tx_byte, transmit, mem_raddr, mem_waddr, mem_dwrite, mem_write_en,
           cpu_run, cpu_startaddr, cpu_active
  );

  modport slave (
    output rx_byte, received, is_transmitting, mem_dread, cpu_halted,
    input  tx_byte, transmit, mem_raddr, mem_waddr, mem_dwrite, mem_write_en,
           cpu_run, cpu_startaddr, cpu_active
  );
endinterface

// File: rtl/monitor_tx.sv
// Byte-send helper: waits for the UART transmitter to be idle, issues a
// one-cycle send strobe, holds one cycle so the busy flag can rise, then
// waits for the transmitter to drain and pulses done_o.
module monitor_tx
  import monitor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       is_transmitting_i,
  output logic       transmit_o,
  output logic [7:0] tx_byte_o,
  output logic       done_o
);

  tx_state_e  state_q;
  logic       transmit_q;
  logic       done_q;
  logic [7:0] byte_q;

  // Send sequencer with registered strobe and completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= T_IDLE;
      transmit_q <= 1'b0;
      done_q     <= 1'b0;
      byte_q     <= 8'h00;
    end else begin
      transmit_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        T_IDLE: begin
          if (start_i) begin
            byte_q  <= byte_i;
            state_q <= T_SEND;
          end
        end
        T_SEND: begin
          if (!is_transmitting_i) begin
            transmit_q <= 1'b1;
            state_q    <= T_HOLD;
          end
        end
        // Busy flag lags the strobe by a cycle; do not sample it yet.
        T_HOLD: begin
          state_q <= T_WAIT;
        end
        T_WAIT: begin
          if (!is_transmitting_i) begin
            done_q  <= 1'b1;
            state_q <= T_IDLE;
          end
        end
        default: begin
          state_q <= T_IDLE;
        end
      endcase
    end
  end

  assign transmit_o = transmit_q;
  assign tx_byte_o  = byte_q;
  assign done_o     = done_q;

endmodule

// File: rtl/cpu_monitor.sv
// Host-side boot monitor: parses L/D/R command bytes from the UART, loads
// and dumps RAM, launches the CPU and reports its halt. Ownership of RAM
// and UART passes to the CPU while cpu_active is high.
// Optional feature macro: MONITOR_DUMP_EN enables the 'D' (dump) command
// and its RAM read path; without it 'D' is answered with '?' and
// mem_raddr is held at zero.
module cpu_monitor
  import monitor_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input logic           clk,
  input logic           rst,
  cpu_monitor_if.master bus
);

  mon_state_e            state_q;
  logic [7:0]            cmd_q;
  logic [7:0]            ah_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [8:0]            cnt_q;
  logic                  tx_start_q;
  logic [7:0]            tx_data_q;
  logic [ADDR_WIDTH-1:0] mem_waddr_q;
  logic [7:0]            mem_dwrite_q;
  logic                  mem_write_en_q;
  logic                  cpu_run_q;
  logic [ADDR_WIDTH-1:0] cpu_startaddr_q;
  logic                  cpu_active_q;
  logic                  tx_done_s;
  logic [15:0]           addr_full_s;
  logic [ADDR_WIDTH-1:0] addr_rx_s;

  // Full 16-bit address from the two argument bytes, truncated to RAM size
  assign addr_full_s = {ah_q, bus.rx_byte};
  assign addr_rx_s   = ADDR_WIDTH'(addr_full_s);

`ifdef MONITOR_DUMP_EN
  logic [ADDR_WIDTH-1:0] mem_raddr_q;
`endif

  // Command sequencer: decode, argument collection, load/dump/run control
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cmd_q           <= 8'h00;
      ah_q            <= 8'h00;
      addr_q          <= '0;
      cnt_q           <= 9'd0;
      tx_start_q      <= 1'b0;
      tx_data_q       <= 8'h00;
      mem_waddr_q     <= '0;
      mem_dwrite_q    <= 8'h00;
      mem_write_en_q  <= 1'b0;
      cpu_run_q       <= 1'b0;
      cpu_startaddr_q <= '0;
      cpu_active_q    <= 1'b0;
`ifdef MONITOR_DUMP_EN
      mem_raddr_q     <= '0;
`endif
    end else begin
      mem_write_en_q <= 1'b0;
      cpu_run_q      <= 1'b0;
      tx_start_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.received) begin
            cmd_q <= bus.rx_byte;
            if ((bus.rx_byte == CMD_LOAD) || (bus.rx_byte == CMD_RUN)) begin
              state_q <= S_GETAH;
            end
`ifdef MONITOR_DUMP_EN
            else if (bus.rx_byte == CMD_DUMP) begin
              state_q <= S_GETAH;
            end
`endif
            else begin
              tx_data_q  <= RPL_ERR;
              tx_start_q <= 1'b1;
              state_q    <= S_ACK;
            end
          end
        end
        S_GETAH: begin
          if (bus.received) begin
            ah_q    <= bus.rx_byte;
            state_q <= S_GETAL;
          end
        end
        S_GETAL: begin
          if (bus.received) begin
            addr_q <= addr_rx_s;
            if (cmd_q == CMD_RUN) begin
              cpu_startaddr_q <= addr_rx_s;
              state_q         <= S_RUN;
            end else begin
              state_q <= S_GETLEN;
            end
          end
        end
        S_GETLEN: begin
          if (bus.received) begin
            cnt_q <= len_to_count(bus.rx_byte);
`ifdef MONITOR_DUMP_EN
            state_q <= (cmd_q == CMD_LOAD) ? S_LOAD : S_RDADDR;
`else
            state_q <= S_LOAD;
`endif
          end
        end
        // Write strobe lands in the cycle after each data byte arrives.
        S_LOAD: begin
          if (bus.received) begin
            mem_write_en_q <= 1'b1;
            mem_waddr_q    <= addr_q;
            mem_dwrite_q   <= bus.rx_byte;
            addr_q         <= addr_q + 1'b1;
            cnt_q          <= cnt_q - 9'd1;
            if (cnt_q == 9'd1) begin
              tx_data_q  <= RPL_OK;
              tx_start_q <= 1'b1;
              state_q    <= S_ACK;
            end
          end
        end
`ifdef MONITOR_DUMP_EN
        S_RDADDR: begin
          mem_raddr_q <= addr_q;
          state_q     <= S_RDW1;
        end
        S_RDW1: begin
          state_q <= S_RDW2;
        end
        // RAM data is valid two clocks after the address edge.
        S_RDW2: begin
          tx_data_q  <= bus.mem_dread;
          tx_start_q <= 1'b1;
          state_q    <= S_TXSEND;
        end
        S_TXSEND: begin
          state_q <= S_TXWAIT;
        end
        S_TXWAIT: begin
          if (tx_done_s) begin
            if (cnt_q == 9'd1) begin
              state_q <= S_IDLE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              cnt_q   <= cnt_q - 9'd1;
              state_q <= S_RDADDR;
            end
          end
        end
`endif
        S_RUN: begin
          cpu_run_q    <= 1'b1;
          cpu_active_q <= 1'b1;
          state_q      <= S_RUNWAIT;
        end
        // A halt coinciding with the start pulse belongs to a previous run.
        S_RUNWAIT: begin
          if (bus.cpu_halted && !cpu_run_q) begin
            cpu_active_q <= 1'b0;
            tx_data_q    <= RPL_HALT;
            tx_start_q   <= 1'b1;
            state_q      <= S_ACK;
          end
        end
        S_ACK: begin
          if (tx_done_s) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  monitor_tx u_tx (
    .clk               (clk),
    .rst               (rst),
    .start_i           (tx_start_q),
    .byte_i            (tx_data_q),
    .is_transmitting_i (bus.is_transmitting),
    .transmit_o        (bus.transmit),
    .tx_byte_o         (bus.tx_byte),
    .done_o            (tx_done_s)
  );

  assign bus.mem_waddr     = mem_waddr_q;
  assign bus.mem_dwrite    = mem_dwrite_q;
  assign bus.mem_write_en  = mem_write_en_q;
  assign bus.cpu_run       = cpu_run_q;
  assign bus.cpu_startaddr = cpu_startaddr_q;
  assign bus.cpu_active    = cpu_active_q;
`ifdef MONITOR_DUMP_EN
  assign bus.mem_raddr     = mem_raddr_q;
`else
  assign bus.mem_raddr     = '0;
`endif

endmodule

// File: doc/cpu_monitor.md
# cpu_monitor

Host-side boot monitor on the far end of the CPU's memory and UART byte interfaces. It takes command bytes from the UART receiver, writes program bytes into the shared RAM and dumps RAM back over the UART transmitter. It then launches the CPU at a given address and reports when the CPU halts. While the CPU runs, the monitor releases RAM and UART ownership to it via `cpu_active`.

## Interface
- `ADDR_WIDTH`, 9, RAM address width; must match the CPU.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_byte` in 8: received UART byte, valid while `received` is high.
- `received` in 1: one-cycle pulse per received byte.
- `tx_byte` out 8: byte to transmit.
- `transmit` out 1: one-cycle send strobe.
- `is_transmitting` in 1: transmitter busy.
- `mem_raddr` out ADDR_WIDTH: RAM read address.
- `mem_dread` in 8: RAM read data.
- `mem_waddr` out ADDR_WIDTH: RAM write address.
- `mem_dwrite` out 8: RAM write data.
- `mem_write_en` out 1: one-cycle write strobe.
- `cpu_run` out 1: one-cycle start pulse; drives the CPU's start input.
- `cpu_startaddr` out ADDR_WIDTH: CPU start address, stable while `cpu_run` is high.
- `cpu_halted` in 1: one-cycle pulse from the CPU on HLT.
- `cpu_active` out 1: CPU owns RAM/UART; the top-level muxes select the CPU when this is high.

## Operation
- Commands (the opcode byte followed by argument bytes):
  - `L` (0x4C) AH AL N data×N: write N bytes starting at address {AH,AL}, then reply `K` (0x4B).
  - `D` (0x44) AH AL N: transmit N bytes read from {AH,AL}.
  - `R` (0x52) AH AL: start the CPU at {AH,AL}; reply `H` (0x48) on halt.
  - Any other opcode: reply `?` (0x3F) and return to IDLE.
- Address and length rules:
  - Address = {AH,AL} truncated to the low ADDR_WIDTH bits.
  - The address increments modulo 2^ADDR_WIDTH, so transfers wrap past the top of RAM.
  - N is 8 bits; N=0 means 256 bytes.
- States and transitions:
  - IDLE: wait for an opcode byte.
  - GETAH → GETAL: collect the address bytes.
  - GETLEN: collect N (`L` and `D` only; `R` goes from GETAL straight to RUN).
  - LOAD: each received byte causes one `mem_write_en` pulse, then the address increments and the count decrements. When the count is exhausted → ACK(`K`).
  - RDADDR → RDW1 → RDW2 (capture `mem_dread`) → TXSEND → TXWAIT: loop N times, then → IDLE.
  - RUN: pulse `cpu_run` and set `cpu_active` → RUNWAIT.
  - RUNWAIT: wait for `cpu_halted`, then clear `cpu_active` → ACK(`H`).
  - ACK: transmit the reply byte → IDLE.
- Transmit handshake: `transmit` is asserted only in a cycle where `is_transmitting` is low. TXWAIT holds one extra cycle before the busy flag is sampled again.
- Received bytes are ignored while `cpu_active` is high, because they belong to the CPU.
- No write occurs outside the LOAD state.

## Timing
- Reset values: every output is 0, including `cpu_active`; the state is IDLE.
- Reset mid-command or mid-run: abort immediately. No further writes or transmits occur, and `cpu_active` drops in the same edge.
- Write: `mem_write_en` is high exactly in the cycle after the `received` pulse of the data byte, with `mem_waddr`/`mem_dwrite` valid in that cycle.
- Read latency: `mem_dread` is sampled 2 clocks after the edge that loads `mem_raddr`.
- `cpu_run` is high for exactly 1 cycle; `cpu_active` rises on the same edge.
- A `cpu_halted` pulse in the same cycle as `cpu_run` is ignored.
- Back-to-back `received` pulses (one per cycle) must be accepted without loss in GET*/LOAD.

## Configuration
- `MONITOR_DUMP_EN`:
  - Defined: the `D` command is implemented, including the RD*/TX* read path.
  - Undefined: `D` is handled as an unknown opcode and answered with `?`, and `mem_raddr` is tied to 0.

## Structure
- Package `monitor_pkg`: state enumeration, command/reply byte constants (`L`, `D`, `R`, `K`, `H`, `?`).
- Sub-module `monitor_tx`: byte-send helper implementing the transmit/`is_transmitting` handshake with a `done` pulse. It is shared by ACK and the dump path.

## Test plan
- Load: `L` 0x00 0x10 0x03 0xAA 0xBB 0xCC → writes RAM[0x010..0x012] = AA, BB, CC, then `K` is transmitted.
- Dump (with `MONITOR_DUMP_EN`): after the load above, `D` 0x00 0x10 0x03 → transmits AA, BB, CC in order, each `transmit` pulse occurring only while `is_transmitting` is low.
- Run: `R` 0x00 0x10 → one-cycle `cpu_run` with `cpu_startaddr`=0x010 and `cpu_active`=1. A `received` byte during the run causes no RAM write. `cpu_halted` → `cpu_active`=0, then `H` is transmitted.
- Wrap: `L` 0x01 0xFF 0x02 0x11 0x22 with ADDR_WIDTH=9 → RAM[0x1FF]=0x11, RAM[0x000]=0x22.
- Unknown opcode and N=0: opcode 0x5A → `?`. `L` 0x00 0x00 0x00 followed by 256 bytes → 256 writes, then `K`.
- Reset mid-load: assert `rst` after the 2nd data byte of an N=4 load → no further writes, all outputs 0, and the next `L` command works normally.
